// File: rtl/infifo_dispatcher.sv
// Packet dispatcher: steers each upstream packet, word by word, to the next free
// thread input FIFO (round-robin from the last grant) and tracks thread ownership.
module infifo_dispatcher #(
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CTRL_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  output logic                   in_rdy,
  input  logic [NUM_THREADS-1:0] df_in_full,
  input  logic [NUM_THREADS-1:0] thread_done,
  output logic [DATA_WIDTH-1:0]  df_in_data_out,
  output logic [CTRL_WIDTH-1:0]  df_in_ctrl_out,
  output logic [NUM_THREADS-1:0] df_in_wr_out,
  output logic [NUM_THREADS-1:0] thread_busy,
  output logic [NUM_THREADS-1:0] thread_start
);

  localparam int unsigned IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       cand, scan_idx, target;
  logic                   cand_vld, accept, ctrl_nz;
  logic [NUM_THREADS-1:0] busy_q, busy_d, start_q, start_d, wr_q, wr_d;
  logic [NUM_THREADS-1:0] grant_oh, hold_mask;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;

  // First free, non-full thread after the last grant, with wrap
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
      scan_idx = IDX_W'((32'(last_grant_q) + k) % NUM_THREADS);
      if (!cand_vld && !busy_q[scan_idx] && !df_in_full[scan_idx]) begin
        cand_vld = 1'b1;
        cand     = scan_idx;
      end
    end
  end

  assign in_rdy  = (state_q == S_IDLE) ? cand_vld : ~df_in_full[cur_q];
  assign accept  = in_wr & in_rdy;
  assign ctrl_nz = |in_ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Packet framing: header words (ctrl!=0), payload (ctrl==0), nonzero ctrl in payload ends it
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_IDLE:    state_d = ctrl_nz ? S_HDR : S_PAYLOAD;
        S_HDR:     if (!ctrl_nz) state_d = S_PAYLOAD;
        S_PAYLOAD: if (ctrl_nz) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    target       = (state_q == S_IDLE) ? cand : cur_q;
    grant_oh     = '0;
    grant_oh[target] = 1'b1;
    hold_mask    = '0;
    if (state_q != S_IDLE) hold_mask[cur_q] = 1'b1;
    // Owner of the in-flight packet cannot be released mid-packet
    busy_d       = busy_q & ~(thread_done & ~hold_mask);
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    start_d      = '0;
    wr_d         = '0;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    if (accept) begin
      wr_d   = grant_oh;
      data_d = in_data;
      ctrl_d = in_ctrl;
      if (state_q == S_IDLE) begin
        cur_d        = cand;
        last_grant_d = cand;
        busy_d       = busy_d | grant_oh;
        start_d      = grant_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q        <= '0;
      last_grant_q <= IDX_W'(NUM_THREADS - 1);
      busy_q       <= '0;
      start_q      <= '0;
      wr_q         <= '0;
      data_q       <= '0;
      ctrl_q       <= '0;
    end else begin
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign df_in_data_out = data_q;
  assign df_in_ctrl_out = ctrl_q;
  assign df_in_wr_out   = wr_q;
  assign thread_busy    = busy_q;
  assign thread_start   = start_q;

endmodule

// File: doc/infifo_dispatcher.md
INFIFO_DISPATCHER -- requirements
Module: infifo_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_THREADS, default 8, giving the number of thread input FIFOs served.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, giving the packet data word width.
REQ-003 The block SHALL have parameter CTRL_WIDTH, default 8, giving the packet control word width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH  upstream packet word.
REQ-007 in_ctrl  input  CTRL_WIDTH  upstream control word; nonzero marks a header word or the last word.
REQ-008 in_wr  input  1  upstream word valid; accepted only when in_rdy=1.
REQ-009 in_rdy  output  1  the dispatcher can accept a word this cycle.
REQ-010 df_in_full  input  NUM_THREADS  per-thread input FIFO full flag.
REQ-011 thread_done  input  NUM_THREADS  one-cycle pulse; the thread has finished its packet and is free.
REQ-012 df_in_data_out  output  DATA_WIDTH  registered word, broadcast to all thread FIFOs.
REQ-013 df_in_ctrl_out  output  CTRL_WIDTH  registered control word, broadcast.
REQ-014 df_in_wr_out  output  NUM_THREADS  registered one-hot write strobe to the selected thread FIFO.
REQ-015 thread_busy  output  NUM_THREADS  the thread owns an undelivered or unfinished packet.
REQ-016 thread_start  output  NUM_THREADS  registered one-cycle pulse when a thread receives the first word of a packet.

Function
REQ-017 The FSM SHALL have states IDLE, HDR and PAYLOAD, with a register cur holding the assigned thread index.
REQ-018 Candidate thread in IDLE: the first index i for which thread_busy[i]=0 and df_in_full[i]=0, searched from (last_grant+1) mod NUM_THREADS upward with wrap.
REQ-019 in_rdy in IDLE: 1 iff a candidate exists.
REQ-020 in_rdy in HDR or PAYLOAD: ~df_in_full[cur].
REQ-021 An accepted word in IDLE SHALL:
- set cur and last_grant to the candidate;
- set thread_busy[candidate];
- pulse thread_start[candidate] on the next cycle;
- move to HDR if in_ctrl!=0, else to PAYLOAD.
REQ-022 An accepted word in HDR SHALL stay in HDR while in_ctrl!=0 and move to PAYLOAD when in_ctrl=0.
REQ-023 An accepted word in PAYLOAD with in_ctrl!=0 is the last word; the FSM SHALL return to IDLE.
REQ-024 An accepted word in PAYLOAD with in_ctrl=0 SHALL keep the FSM in PAYLOAD.
REQ-025 Every accepted word SHALL appear on df_in_data_out/df_in_ctrl_out exactly 1 cycle later, with df_in_wr_out one-hot at cur.
REQ-026 df_in_wr_out SHALL be all-zero in any cycle following a cycle with no accepted word.
REQ-027 in_wr while in_rdy=0 SHALL be ignored: no write, no state change.
REQ-028 thread_done[i] SHALL clear thread_busy[i] on the next edge.
REQ-029 thread_done for a non-busy thread SHALL be ignored.
REQ-030 If a set and a clear of thread_busy[i] occur in the same cycle, the set SHALL win.
REQ-031 Packet ownership SHALL NOT change mid-packet; thread_done[cur] while in HDR or PAYLOAD leaves thread_busy[cur] set until the packet is complete and a later thread_done arrives.
REQ-032 Back-to-back packets SHALL be accepted with zero idle cycles: the last word in one cycle, the next packet's first word in the following cycle.

Reset
REQ-033 While reset=1 at an edge:
- state=IDLE, cur=0, last_grant=NUM_THREADS-1, so the first grant is thread 0;
- thread_busy=0, thread_start=0, df_in_wr_out=0;
- df_in_data_out=0, df_in_ctrl_out=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet, with no further writes issued; the remaining upstream words are the source's responsibility.

Verification
REQ-035 After reset, send a packet with ctrl FF,00,00,80 -> df_in_wr_out=0x01 for 4 cycles starting 1 cycle later; thread_start=0x01 for 1 cycle; thread_busy=0x01.
REQ-036 Send 3 back-to-back packets with no done pulses -> threads 0, 1, 2 in order with no gaps; thread_busy=0x07.
REQ-037 Fill all 8 threads -> in_rdy=0 in IDLE; pulse thread_done[5] -> in_rdy=1 next cycle and the next packet goes to thread 5.
REQ-038 last_grant=6, thread_busy=0x7E -> next packet to thread 7, then to thread 0 (wrap).
REQ-039 Pulse thread_done[3] with thread 3 idle -> no change; set df_in_full[cur]=1 mid-payload -> in_rdy=0 and no writes until it clears.
REQ-040 Assert reset during PAYLOAD -> next cycle all outputs 0 and thread_busy=0; the following packet goes to thread 0.
